// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the pipeline hazard/stall controller.
//   STG_*       : bit positions of the per-pipeline-register hold vector
//   mem_type_e  : memory-op type encodings shared with the decode stage
package hazard_pkg;

   localparam int STG_IFID  = 0;
   localparam int STG_IDEX  = 1;
   localparam int STG_EXMEM = 2;
   localparam int STG_MEMWB = 3;
   localparam int NUM_STG   = 4;

   typedef enum logic [1:0] {
      MEM_NONE = 2'b00,
      MEM_LOAD = 2'b01,
      MEM_STOR = 2'b10
   } mem_type_e;

endpackage

// File: rtl/load_tracker.sv
// load_tracker
// Remembers the destination registers of loads that have left EX but whose
// data is not yet forwardable. Each entry is {valid, reg}; entries shift by
// one position on every advance, the oldest entry falls off the end.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (clears valids)
//   adv           : shift enable (EX/MEM register not held)
//   ld_vld/ld_reg : entry captured into position 0 on advance
//   cmp_a/cmp_b   : register indices looked up against all valid entries
//   hit           : some valid entry matches cmp_a or cmp_b
module load_tracker #(
   parameter int REG_W = 5,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,
   input  logic             ld_vld,
   input  logic [REG_W-1:0] ld_reg,
   input  logic [REG_W-1:0] cmp_a,
   input  logic [REG_W-1:0] cmp_b,
   output logic             hit
);

   logic             vld_q [DEPTH];
   logic [REG_W-1:0] reg_q [DEPTH];

   // Valid bits carry the control meaning and are the only reset state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) vld_q[k] <= 1'b0;
      end else if (adv) begin
         vld_q[0] <= ld_vld;
         for (int k = 1; k < DEPTH; k++) vld_q[k] <= vld_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         reg_q[0] <= ld_reg;
         for (int k = 1; k < DEPTH; k++) reg_q[k] <= reg_q[k-1];
      end
   end

   always_comb begin
      hit = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (vld_q[k] && (reg_q[k] == cmp_a || reg_q[k] == cmp_b)) hit = 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Stall / bubble / flush controller for the five-stage core.
// Parameters: REG_W register index width, LOAD_LAT load-result latency
// after EX (1..4), CNT_W stall-cycle counter width.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   id_valid, id_rs, id_rt    : decode-stage instruction and its sources
//   ex_is_load, ex_rd         : EX-stage load flag and destination
//   ex_busy                   : multicycle EX op not finished
//   if_stall_i                : instruction fetch miss
//   mem_stall_i, data_ok      : data access outstanding / data returned
//   flush_i                   : redirect/exception flush pulse
//   cnt_clr_i                 : synchronous clear of the stall counter
//   stall_o[3:0]              : hold IF/ID, ID/EX, EX/MEM, MEM/WB
//   bubble_o                  : insert NOP into ID/EX
//   flush_o[1:0]              : clear IF/ID, ID/EX
//   stall_cnt_o               : saturating count of IF/ID hold cycles
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_W    = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             ex_is_load,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_busy,
   input  logic             if_stall_i,
   input  logic             mem_stall_i,
   input  logic             data_ok,
   input  logic             flush_i,
   input  logic             cnt_clr_i,
   output logic [3:0]       stall_o,
   output logic             bubble_o,
   output logic [1:0]       flush_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   logic mem_hold;
   logic hold_ex;
   logic ex_ld_vld;
   logic hit_ex;
   logic hit_trk;
   logic load_use;
   logic flush_pend;
   logic flush_now;

   // Hazard detection
   assign mem_hold  = mem_stall_i & ~data_ok;
   assign hold_ex   = mem_hold | ex_busy;
   assign ex_ld_vld = ex_is_load & (ex_rd != '0);
   assign hit_ex    = ex_ld_vld & ((ex_rd == id_rs) | (ex_rd == id_rt));
   assign load_use  = id_valid & (hit_ex | hit_trk);

   // The tracker advances with the EX/MEM register, so a memory hold or a
   // busy EX unit stretches the load-use window by the length of the hold.
   generate
      if (LOAD_LAT > 1) begin : g_trk
         load_tracker #(
            .REG_W (REG_W),
            .DEPTH (LOAD_LAT - 1)
         ) u_trk (
            .clk    (clk),
            .rst    (rst),
            .adv    (~hold_ex),
            .ld_vld (ex_ld_vld),
            .ld_reg (ex_rd),
            .cmp_a  (id_rs),
            .cmp_b  (id_rt),
            .hit    (hit_trk)
         );
      end else begin : g_no_trk
         assign hit_trk = 1'b0;
      end
   endgenerate

   // Stall / bubble / flush outputs
   assign stall_o[STG_MEMWB] = mem_hold;
   assign stall_o[STG_EXMEM] = hold_ex;
   assign stall_o[STG_IDEX]  = hold_ex;
   assign stall_o[STG_IFID]  = hold_ex | load_use | if_stall_i;

   // A flush cannot be applied while memory holds the pipe; it is parked in
   // flush_pend and released in the first cycle the hold drops. A new
   // flush_i arriving in that cycle simply merges with the parked one.
   assign flush_now = (flush_i | flush_pend) & ~mem_hold;
   assign flush_o   = {2{flush_now}};

   assign bubble_o  = (load_use | if_stall_i) & ~hold_ex & ~flush_now;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_pend <= 1'b0;
      end else if (flush_now) begin
         flush_pend <= 1'b0;
      end else if (flush_i & mem_hold) begin
         flush_pend <= 1'b1;
      end
   end

   // Stall-cycle counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_o <= '0;
      end else if (cnt_clr_i) begin
         stall_cnt_o <= '0;
      end else if (stall_o[STG_IFID]) begin
         stall_cnt_o <= sat_inc(stall_cnt_o);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Drives two hazard_ctrl instances (LOAD_LAT=3 and LOAD_LAT=1, both with a
// 4-bit stall counter) from the same inputs and compares them with a
// behavioural model holding the recent-load history in a queue.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs, id_rt;
   logic       ex_is_load;
   logic [4:0] ex_rd;
   logic       ex_busy, if_stall_i, mem_stall_i, data_ok, flush_i, cnt_clr_i;

   logic [3:0] st_a, st_b;
   logic       bub_a, bub_b;
   logic [1:0] fl_a, fl_b;
   logic [3:0] cnt_a, cnt_b;

   int checks   = 0;
   int failures = 0;

   // Model state: destination regs of loads that left EX (newest first,
   // -1 = no load), pending flush, counters.
   int q_a[$];
   bit pend_m;
   int cnt_a_m, cnt_b_m;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_busy(ex_busy),
      .if_stall_i(if_stall_i), .mem_stall_i(mem_stall_i), .data_ok(data_ok),
      .flush_i(flush_i), .cnt_clr_i(cnt_clr_i),
      .stall_o(st_a), .bubble_o(bub_a), .flush_o(fl_a), .stall_cnt_o(cnt_a)
   );

   hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_busy(ex_busy),
      .if_stall_i(if_stall_i), .mem_stall_i(mem_stall_i), .data_ok(data_ok),
      .flush_i(flush_i), .cnt_clr_i(cnt_clr_i),
      .stall_o(st_b), .bubble_o(bub_b), .flush_o(fl_b), .stall_cnt_o(cnt_b)
   );

   // Expected {stall[3:0], bubble, flush[1:0]} for the current inputs.
   function automatic logic [6:0] exp_out(input bit use_hist);
      logic       mh, s2, hit, lu, fl, bub;
      logic [3:0] st;
      mh  = mem_stall_i & ~data_ok;
      s2  = mh | ex_busy;
      hit = ex_is_load && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
      if (use_hist) begin
         foreach (q_a[i])
            if (q_a[i] >= 0 && (q_a[i] == int'(id_rs) || q_a[i] == int'(id_rt))) hit = 1'b1;
      end
      lu  = id_valid & hit;
      fl  = (flush_i | pend_m) & ~mh;
      st  = {mh, s2, s2, s2 | lu | if_stall_i};
      bub = (lu | if_stall_i) & ~s2 & ~fl;
      return {st, bub, fl, fl};
   endfunction

   task automatic model_reset();
      q_a.delete();
      pend_m  = 1'b0;
      cnt_a_m = 0;
      cnt_b_m = 0;
   endtask

   task automatic idle_inputs();
      id_valid = 0; id_rs = 0; id_rt = 0; ex_is_load = 0; ex_rd = 0;
      ex_busy = 0; if_stall_i = 0; mem_stall_i = 0; data_ok = 0;
      flush_i = 0; cnt_clr_i = 0;
   endtask

   // Advance the model across the coming clock edge, then wait past it.
   task automatic tick();
      logic [6:0] ea, eb;
      logic       mh;
      ea = exp_out(1'b1);
      eb = exp_out(1'b0);
      mh = mem_stall_i & ~data_ok;
      if (!rst) begin
         if (cnt_clr_i) cnt_a_m = 0; else if (ea[3] && cnt_a_m < 15) cnt_a_m++;
         if (cnt_clr_i) cnt_b_m = 0; else if (eb[3] && cnt_b_m < 15) cnt_b_m++;
         if (ea[1]) pend_m = 1'b0; else if (flush_i && mh) pend_m = 1'b1;
         if (!(mh || ex_busy)) begin
            q_a.push_front((ex_is_load && ex_rd != 0) ? int'(ex_rd) : -1);
            if (q_a.size() > 2) void'(q_a.pop_back());
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      model_reset();
      #2;
      checks++; if ({st_a, bub_a, fl_a} !== 7'b0) begin failures++; $display("FAIL reset_out_a got=%b exp=%b", {st_a, bub_a, fl_a}, 7'b0); end
      checks++; if ({st_b, bub_b, fl_b} !== 7'b0) begin failures++; $display("FAIL reset_out_b got=%b exp=%b", {st_b, bub_b, fl_b}, 7'b0); end
      checks++; if (cnt_a !== 4'd0) begin failures++; $display("FAIL reset_cnt_a got=%0d exp=0", cnt_a); end
      checks++; if (cnt_b !== 4'd0) begin failures++; $display("FAIL reset_cnt_b got=%0d exp=0", cnt_b); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_lat1_load_use();
      idle_inputs();
      tick(); tick(); tick();
      for (int c = 0; c < 3; c++) begin
         id_valid = 1; id_rt = 0;
         case (c)
            0: begin ex_is_load = 1; ex_rd = 8; id_rs = 8; end
            1: begin ex_is_load = 0; ex_rd = 8; id_rs = 8; end
            default: begin ex_is_load = 1; ex_rd = 0; id_rs = 0; end
         endcase
         #2;
         checks++; if ({st_a, bub_a, fl_a} !== exp_out(1'b1)) begin failures++; $display("FAIL lat1_model_a c=%0d got=%b exp=%b", c, {st_a, bub_a, fl_a}, exp_out(1'b1)); end
         checks++; if ({st_b, bub_b, fl_b} !== exp_out(1'b0)) begin failures++; $display("FAIL lat1_model_b c=%0d got=%b exp=%b", c, {st_b, bub_b, fl_b}, exp_out(1'b0)); end
         checks++; if ({st_b, bub_b} !== ((c == 0) ? 5'b0001_1 : 5'b0000_0)) begin failures++; $display("FAIL lat1_stall_b c=%0d got=%b exp=%b", c, {st_b, bub_b}, (c == 0) ? 5'b0001_1 : 5'b0000_0); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_lat3_tracker();
      logic [3:0] exp_st;
      idle_inputs();
      tick(); tick(); tick();
      // Plain window: dependents 1 and 2 cycles after the load stall.
      for (int c = 0; c < 4; c++) begin
         ex_is_load = (c == 0); ex_rd = 5;
         id_valid = (c != 0); id_rt = 5; id_rs = 0;
         #2;
         exp_st = (c == 1 || c == 2) ? 4'b0001 : 4'b0000;
         checks++; if ({st_a, bub_a, fl_a} !== exp_out(1'b1)) begin failures++; $display("FAIL lat3_model c=%0d got=%b exp=%b", c, {st_a, bub_a, fl_a}, exp_out(1'b1)); end
         checks++; if (st_a !== exp_st) begin failures++; $display("FAIL lat3_window c=%0d got=%b exp=%b", c, st_a, exp_st); end
         tick();
      end
      idle_inputs();
      tick(); tick();
      // Same window with a 2-cycle memory hold inserted after the load.
      for (int c = 0; c < 6; c++) begin
         ex_is_load = (c == 0); ex_rd = 5;
         id_valid = (c != 0); id_rt = 5; id_rs = 0;
         mem_stall_i = (c == 1 || c == 2); data_ok = 0;
         #2;
         case (c)
            1, 2:    exp_st = 4'b1111;
            3, 4:    exp_st = 4'b0001;
            default: exp_st = 4'b0000;
         endcase
         checks++; if ({st_a, bub_a, fl_a} !== exp_out(1'b1)) begin failures++; $display("FAIL lat3_hold_model c=%0d got=%b exp=%b", c, {st_a, bub_a, fl_a}, exp_out(1'b1)); end
         checks++; if (st_a !== exp_st) begin failures++; $display("FAIL lat3_hold_window c=%0d got=%b exp=%b", c, st_a, exp_st); end
         checks++; if (bub_a !== (exp_st == 4'b0001)) begin failures++; $display("FAIL lat3_hold_bubble c=%0d got=%b exp=%b", c, bub_a, exp_st == 4'b0001); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_deferred_flush();
      logic [1:0] exp_fl;
      for (int pass = 0; pass < 2; pass++) begin
         idle_inputs();
         tick();
         for (int c = 0; c < 6; c++) begin
            mem_stall_i = (c < 4); data_ok = 0;
            // pass 1 adds a fresh flush in the release cycle; it must merge.
            flush_i = (c == 0) || (pass == 1 && c == 4);
            #2;
            exp_fl = (c == 4) ? 2'b11 : 2'b00;
            checks++; if (fl_a !== exp_fl) begin failures++; $display("FAIL defer_flush_a p=%0d c=%0d got=%b exp=%b", pass, c, fl_a, exp_fl); end
            checks++; if ({st_b, bub_b, fl_b} !== exp_out(1'b0)) begin failures++; $display("FAIL defer_model_b p=%0d c=%0d got=%b exp=%b", pass, c, {st_b, bub_b, fl_b}, exp_out(1'b0)); end
            tick();
         end
      end
      idle_inputs();
   endtask

   task automatic test_busy_load_use();
      idle_inputs();
      tick();
      for (int c = 0; c < 8; c++) begin
         ex_busy = (c < 6); ex_is_load = 1; ex_rd = 7;
         id_valid = 1; id_rs = 7; id_rt = 3;
         #2;
         checks++; if ({st_b, bub_b} !== ((c < 6) ? 5'b0111_0 : 5'b0001_1)) begin failures++; $display("FAIL busy_lu_b c=%0d got=%b exp=%b", c, {st_b, bub_b}, (c < 6) ? 5'b0111_0 : 5'b0001_1); end
         checks++; if ({st_a, bub_a, fl_a} !== exp_out(1'b1)) begin failures++; $display("FAIL busy_model_a c=%0d got=%b exp=%b", c, {st_a, bub_a, fl_a}, exp_out(1'b1)); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_cnt_sat();
      idle_inputs();
      cnt_clr_i = 1;
      tick();
      cnt_clr_i = 0;
      for (int c = 0; c < 20; c++) begin
         if_stall_i = 1;
         #2;
         checks++; if (cnt_a !== 4'(cnt_a_m)) begin failures++; $display("FAIL cnt_run_a c=%0d got=%0d exp=%0d", c, cnt_a, cnt_a_m); end
         tick();
      end
      checks++; if (cnt_a !== 4'd15) begin failures++; $display("FAIL cnt_sat_a got=%0d exp=15", cnt_a); end
      checks++; if (cnt_b !== 4'd15) begin failures++; $display("FAIL cnt_sat_b got=%0d exp=15", cnt_b); end
      cnt_clr_i = 1;
      tick();
      cnt_clr_i = 0;
      if_stall_i = 0;
      #2;
      checks++; if (cnt_a !== 4'd0) begin failures++; $display("FAIL cnt_clr_a got=%0d exp=0", cnt_a); end
      checks++; if (cnt_b !== 4'(cnt_b_m)) begin failures++; $display("FAIL cnt_clr_b got=%0d exp=%0d", cnt_b, cnt_b_m); end
      tick();
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      tick();
      ex_is_load = 1; ex_rd = 9;  tick();
      ex_rd = 10; tick();
      ex_is_load = 0; ex_rd = 0;
      mem_stall_i = 1; data_ok = 0; flush_i = 1;
      tick();
      flush_i = 0; mem_stall_i = 0;
      id_valid = 1; id_rs = 9; id_rt = 10;
      #2;
      checks++; if ({st_a, bub_a, fl_a} !== exp_out(1'b1)) begin failures++; $display("FAIL pre_rst_model_a got=%b exp=%b", {st_a, bub_a, fl_a}, exp_out(1'b1)); end
      checks++; if ({st_a[0], fl_a} !== 3'b1_11) begin failures++; $display("FAIL pre_rst_state_a got=%b exp=%b", {st_a[0], fl_a}, 3'b1_11); end
      rst = 1'b1;
      model_reset();
      #2;
      checks++; if ({st_a, bub_a, fl_a, cnt_a} !== 11'b0) begin failures++; $display("FAIL mid_rst_a got=%b exp=%b", {st_a, bub_a, fl_a, cnt_a}, 11'b0); end
      checks++; if ({st_b, bub_b, fl_b, cnt_b} !== 11'b0) begin failures++; $display("FAIL mid_rst_b got=%b exp=%b", {st_b, bub_b, fl_b, cnt_b}, 11'b0); end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #2;
         checks++; if ({st_a, bub_a, fl_a} !== 7'b0) begin failures++; $display("FAIL post_rst_a c=%0d got=%b exp=%b", c, {st_a, bub_a, fl_a}, 7'b0); end
         checks++; if ({st_b, bub_b, fl_b} !== exp_out(1'b0)) begin failures++; $display("FAIL post_rst_b c=%0d got=%b exp=%b", c, {st_b, bub_b, fl_b}, exp_out(1'b0)); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         id_valid    = ($urandom_range(0, 3) != 0);
         id_rs       = 5'($urandom_range(0, 7));
         id_rt       = 5'($urandom_range(0, 7));
         ex_is_load  = ($urandom_range(0, 1) != 0);
         ex_rd       = 5'($urandom_range(0, 7));
         ex_busy     = ($urandom_range(0, 5) == 0);
         if_stall_i  = ($urandom_range(0, 5) == 0);
         mem_stall_i = ($urandom_range(0, 3) == 0);
         data_ok     = ($urandom_range(0, 2) == 0);
         flush_i     = ($urandom_range(0, 7) == 0);
         cnt_clr_i   = ($urandom_range(0, 15) == 0);
         #2;
         checks++; if ({st_a, bub_a, fl_a} !== exp_out(1'b1)) begin failures++; $display("FAIL rand_a c=%0d got=%b exp=%b", c, {st_a, bub_a, fl_a}, exp_out(1'b1)); end
         checks++; if ({st_b, bub_b, fl_b} !== exp_out(1'b0)) begin failures++; $display("FAIL rand_b c=%0d got=%b exp=%b", c, {st_b, bub_b, fl_b}, exp_out(1'b0)); end
         checks++; if (cnt_a !== 4'(cnt_a_m)) begin failures++; $display("FAIL rand_cnt_a c=%0d got=%0d exp=%0d", c, cnt_a, cnt_a_m); end
         checks++; if (cnt_b !== 4'(cnt_b_m)) begin failures++; $display("FAIL rand_cnt_b c=%0d got=%0d exp=%0d", c, cnt_b, cnt_b_m); end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_lat1_load_use();
      test_lat3_tracker();
      test_deferred_flush();
      test_busy_load_use();
      test_cnt_sat();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard and stall controller for the five-stage core; the next generation of the current stall controller. Generates per-register stall, bubble and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers from cache/memory stalls, multicycle EX busy and load-use hazards. Adds a configurable load-result latency through a load-destination tracker, a pending-flush latch for flushes that arrive during a memory hold, and a saturating stall-cycle counter.

## Interface
- REG_W, 5: register index width
- LOAD_LAT, 1: cycles after EX before load data can be forwarded (1..4); tracker depth = LOAD_LAT-1
- CNT_W, 32: stall-cycle counter width
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- id_valid  in  1  decode stage holds a valid instruction
- id_rs, id_rt  in  REG_W  decode source registers
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  REG_W  EX instruction destination register
- ex_busy  in  1  multicycle mul/div in EX not finished
- if_stall_i  in  1  instruction fetch miss
- mem_stall_i  in  1  data access outstanding
- data_ok  in  1  data returned this cycle
- flush_i  in  1  redirect/exception flush request (single-cycle pulse)
- cnt_clr_i  in  1  synchronous clear of stall counter
- stall_o  out  4  hold enable: [0] IF/ID, [1] ID/EX, [2] EX/MEM, [3] MEM/WB
- bubble_o  out  1  load NOP into ID/EX this cycle
- flush_o  out  2  clear: [0] IF/ID, [1] ID/EX
- stall_cnt_o  out  CNT_W  cycles with stall_o[0] asserted

## Operation
- mem_hold = mem_stall_i & ~data_ok
- stall_o[3] = mem_hold; stall_o[2] = mem_hold | ex_busy; stall_o[1] = stall_o[2]
- stall_o[0] = stall_o[1] | load_use | if_stall_i
- bubble_o = (load_use | if_stall_i) & ~stall_o[1]; never asserted when flush_o[1] is asserted (flush wins)
- load_use = id_valid & (hit_ex | hit_trk); hit_ex = ex_is_load & ex_rd != 0 & (ex_rd == id_rs | ex_rd == id_rt); hit_trk = any valid tracker entry whose reg matches id_rs or id_rt
- Tracker: LOAD_LAT-1 entries {valid, reg}. On a clock edge with ~stall_o[2]: entry0 <= {ex_is_load & ex_rd != 0, ex_rd}, entry k <= entry k-1, last entry discarded. When stall_o[2] is high, the tracker holds. With LOAD_LAT = 1 the tracker is absent and hit_trk = 0.
- Flush: flush_eff = flush_i | flush_pend. flush_o = {2{flush_eff & ~mem_hold}}.
  - flush_pend sets on flush_i & mem_hold and clears on any cycle with flush_o asserted.
  - A flush during ex_busy is not deferred. The EX instruction and the tracker are not flushed.
- Counter increments on each cycle with stall_o[0]. It saturates at all-ones. cnt_clr_i has priority over increment.

## Timing
- All stall, bubble and flush outputs are combinational from inputs plus registered state; zero-cycle latency.
- Reset (async) clears tracker valids, flush_pend and stall_cnt_o. With all inputs low, every output is 0.
- Deferred flush is asserted in the first cycle in which mem_hold is low, which is at least one cycle after flush_i. A new flush_i in that same cycle merges into it and produces a single flush.
- A load sits in the tracker for exactly LOAD_LAT-1 unstalled EX-advance edges after leaving EX.
- A simultaneous load_use and mem_hold yields stall_o = 4'b1111 and bubble_o = 0.
- A reset mid-stall drops all stalls and any pending flush immediately.

## Structure
- hazard_pkg: stage index constants (STG_IFID=0 .. STG_MEMWB=3) and the MEM_LOAD/MEM_STOR type encodings shared with the decode stage
- Sub-module load_tracker (params REG_W, DEPTH): shift register with advance, two compare ports and a hit output. Generate it only when DEPTH > 0.

## Test plan
- LOAD_LAT=1: ex_is_load=1, ex_rd=8, id_rs=8, id_valid=1 -> stall_o=4'b0001, bubble_o=1 for one cycle; next cycle with ex_is_load=0 -> stall_o=0. Repeat with ex_rd=0 -> no stall.
- LOAD_LAT=3: load to r5 leaves EX; dependent id_rt=5 arrives 1 and 2 cycles later -> stall each time; 3 cycles later -> no stall. Inserting mem_hold between the edges extends the window by the hold length.
- flush_i pulse during mem_stall_i=1, data_ok=0 for 4 cycles -> flush_o=0 during the hold, flush_o=2'b11 in the cycle mem_stall_i drops, then 0.
- ex_busy=1 for 6 cycles with a load-use hazard present -> stall_o=4'b0111, bubble_o=0; after busy clears -> stall_o=4'b0001, bubble_o=1.
- CNT_W=4: hold stall_o[0] for 20 cycles -> stall_cnt_o saturates at 15; cnt_clr_i together with a stall -> 0.
- Assert rst with flush_pend set and tracker full -> all outputs 0 immediately; after release, no stale stall or flush occurs.
